// File: rtl/rename_regfile.sv
// Architectural register file with per-register ROB rename tags.
// Commits retire values and clear matching tags; queries bypass a same-cycle commit.
module rename_regfile #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              in_assignment_ena,
    input  logic [4:0]        in_assign_reg,
    input  logic [TAG_W-1:0]  in_assign_tag,
    input  logic [4:0]        in_commit_reg,
    input  logic [TAG_W-1:0]  in_commit_rob,
    input  logic [DATA_W-1:0] in_commit_value,
    input  logic              in_misbranch,
    input  logic [4:0]        in_query_reg1,
    input  logic [4:0]        in_query_reg2,
    output logic [TAG_W-1:0]  out_query_tag1,
    output logic [TAG_W-1:0]  out_query_tag2,
    output logic [DATA_W-1:0] out_query_value1,
    output logic [DATA_W-1:0] out_query_value2
);

    // Entry 0 exists only for uniform indexing; it is never written and never read out.
    logic [DATA_W-1:0] value_q [REG_NUM];
    logic [DATA_W-1:0] value_d [REG_NUM];
    logic [TAG_W-1:0]  tag_q   [REG_NUM];
    logic [TAG_W-1:0]  tag_d   [REG_NUM];

    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        if (ena) begin
            if (in_commit_reg != '0) begin
                value_d[in_commit_reg] = in_commit_value;
                if (tag_q[in_commit_reg] == in_commit_rob) begin
                    tag_d[in_commit_reg] = '0;
                end
            end
            // Flush and rename are applied after the commit clear so they take precedence.
            if (in_misbranch) begin
                for (int unsigned i = 0; i < REG_NUM; i++) begin
                    tag_d[i] = '0;
                end
            end else if (in_assignment_ena && in_assign_reg != '0) begin
                tag_d[in_assign_reg] = in_assign_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    function automatic logic commit_hits(input logic [4:0] r);
        return (r != '0) && (in_commit_reg == r) && (tag_q[r] == in_commit_rob);
    endfunction

    function automatic logic [TAG_W-1:0] query_tag(input logic [4:0] r);
        if (r == '0 || commit_hits(r)) begin
            return '0;
        end
        return tag_q[r];
    endfunction

    function automatic logic [DATA_W-1:0] query_value(input logic [4:0] r);
        if (r == '0) begin
            return '0;
        end
        if (commit_hits(r)) begin
            return in_commit_value;
        end
        return value_q[r];
    endfunction

    always_comb begin
        out_query_tag1   = query_tag(in_query_reg1);
        out_query_tag2   = query_tag(in_query_reg2);
        out_query_value1 = query_value(in_query_reg1);
        out_query_value2 = query_value(in_query_reg2);
    end

endmodule

// File: doc/rename_regfile.md
# rename_regfile

Architectural register file with per-register rename tags. It sits directly downstream of the reorder buffer's commit port, where committed results retire into architectural state. It also serves the decoder: at dispatch the decoder reads each source operand as either a ready value or the ROB tag of its pending producer, and records the destination register's new producer tag.

## Interface

Parameters:
- `REG_NUM`, 32: number of architectural registers; x0 is hard-wired to zero.
- `TAG_W`, 4: ROB tag width (`ROB_WIDTH`); tag 0 means "no pending producer".
- `DATA_W`, 32: register data width (`DATA_WIDTH`).

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `ena`  in  1  global enable; when low all state holds.
- `in_assignment_ena`  in  1  decoder dispatches an instruction with a destination this cycle.
- `in_assign_reg`  in  5  destination register to rename.
- `in_assign_tag`  in  TAG_W  ROB tag allocated to that instruction.
- `in_commit_reg`  in  5  committing destination register; 0 means no commit.
- `in_commit_rob`  in  TAG_W  ROB tag of the committing entry.
- `in_commit_value`  in  DATA_W  committed result.
- `in_misbranch`  in  1  ROB flush pulse; all speculative renames are discarded.
- `in_query_reg1`, `in_query_reg2`  in  5  decoder source operands.
- `out_query_tag1`, `out_query_tag2`  out  TAG_W  pending producer tag; 0 when the value is ready.
- `out_query_value1`, `out_query_value2`  out  DATA_W  architectural value; meaningful only when the matching tag is 0.

## Operation

Storage:
- `value[1..31]` (DATA_W) and `tag[1..31]` (TAG_W).
- Register 0 is never written. Its reads always return value 0 and tag 0.

Rename, at the clock edge when `ena && in_assignment_ena && in_assign_reg != 0 && !in_misbranch`:
- `tag[in_assign_reg] <= in_assign_tag`.

Commit, at the clock edge when `ena && in_commit_reg != 0`:
- `value[in_commit_reg] <= in_commit_value`. This happens unconditionally, including in a misbranch cycle, because the flushing JALR commits its link value in that cycle.
- `tag[in_commit_reg] <= 0` only if `tag[in_commit_reg] == in_commit_rob`. If a younger writer has since renamed the register, its tag is kept.

Rename and commit to the same register in the same cycle:
- The rename tag wins.
- The value is still written.

Misbranch, at the clock edge when `ena && in_misbranch`:
- All tags are cleared to 0.
- A concurrent commit value is written.
- A concurrent rename is dropped.

Query path (combinational):
- For a nonzero query register r, the stored `tag[r]`/`value[r]` are output.
- Same-cycle bypass: if `in_commit_reg == r` and `tag[r] == in_commit_rob`, output tag 0 and `in_commit_value`.
- A same-cycle rename is not bypassed to queries. The decoder must not query a register it renames in the same instruction before issue.

When `ena` is low:
- No state changes.
- Query outputs still reflect stored state and bypass.

## Timing

- Reset takes effect at the first rising edge with `rst=1`. After it, all values and tags are 0, and query outputs are 0/0 for every register.
- Reset mid-operation discards all pending tags. Reset has priority over `ena`.
- Rename and commit become visible in stored state one cycle after the edge.
- Bypass makes a commit visible to queries in the same cycle (0-cycle latency).
- Misbranch takes effect at the edge of the cycle in which the pulse is high. From the next cycle every query returns tag 0.
- Tag wrap-around: tags are compared for equality only. A stale commit whose tag equals a reused newer tag clears it. This is safe because the ROB never reuses a tag while an older writer of the same register is uncommitted.

## Test plan

- Reset → queries of x1 and x31 return value 0, tag 0. After a write attempt to x0 (commit reg 0, and rename reg 0 tag 3), x0 still returns 0/0.
- Rename x5→tag 3. The next cycle a query of x5 returns tag 3. Commit x5, rob 3, value 0x1234 → in that cycle the query returns tag 0, value 0x1234 via bypass, and it stays so afterwards.
- Rename x7→tag 2, then x7→tag 6. Commit x7/rob 2/0xAA → x7 value 0xAA, tag remains 6. Commit x7/rob 6/0xBB → tag 0, value 0xBB.
- In the same cycle, rename x9→tag 4 and commit x9/rob 1/0x55 (tag[x9] was 1) → next cycle tag 4, value 0x55.
- Pending x3=tag 2 and x4=tag 5. Assert `in_misbranch` with commit x1/rob 7/0x1000 and rename x6→tag 8 → next cycle x3, x4 and x6 have tag 0, and x1 holds 0x1000.
- With `ena=0`, rename x2→tag 1 and commit x8/0x77 → no change to x2 or x8.
